uart_cmd_decoder: RTL and testbench
===================================

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 The block SHALL have parameter ECHO_EN, default 1, meaning 1 = echo or acknowledge each received byte on the TX side, 0 = no TX activity.
REQ-002 The block SHALL have port clk  input  1  system clock, with all logic on its rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port rx_data  input  8  received byte, valid only while rx_done=1.
REQ-005 The block SHALL have port rx_done  input  1  one-cycle strobe marking a new received byte.
REQ-006 The block SHALL have port tx_busy  input  1  UART transmitter busy; tx_start is ignored downstream while it is high.
REQ-007 The block SHALL have ports up, down, left, right, run, stop, clear, reset  output  1 each  one-cycle command pulses to the watch/stopwatch top.
REQ-008 The block SHALL have ports time_mode, func_mode  output  1 each  level outputs, toggled by command.
REQ-009 The block SHALL have port tx_start  output  1  one-cycle request to transmit tx_data.
REQ-010 The block SHALL have port tx_data  output  8  byte to transmit, held stable from tx_start until the next tx_start.
REQ-011 The block SHALL have port err  output  1  one-cycle pulse on an unknown command byte.
REQ-012 The block SHALL have port overrun  output  1  one-cycle pulse when a received byte is dropped.
REQ-013 The block SHALL have port cmd_cnt  output  8  count of valid commands executed.

Function
REQ-014 Decode SHALL be case-insensitive: rx_data with bit5 cleared is compared against the table.
REQ-015 The command table SHALL be: 0x55 'U' up; 0x44 'D' down; 0x4C 'L' left; 0x52 'R' right; 0x47 'G' run; 0x53 'S' stop; 0x43 'C' clear; 0x58 'X' reset; 0x4D 'M' toggle time_mode; 0x46 'F' toggle func_mode.
REQ-016 Any other byte SHALL produce an err pulse and no command pulse, mode change or cmd_cnt change.
REQ-017 The 'X' command SHALL pulse reset and, in the same cycle, force time_mode and func_mode to 0.
REQ-018 The FSM SHALL have states IDLE, DECODE and ECHO.
REQ-019 In IDLE, when rx_done=1 or the hold register is valid, the FSM SHALL latch the byte (hold register takes priority) and go to DECODE.
REQ-020 In DECODE, the FSM SHALL register the pulse, toggle, err and cmd_cnt updates, then go to ECHO if ECHO_EN=1, else to IDLE.
REQ-021 In ECHO, when tx_busy=0 the FSM SHALL assert tx_start for one cycle and go to IDLE; while tx_busy=1 it SHALL wait indefinitely.
REQ-022 tx_data SHALL be the uppercase command byte for a valid command, or 0x3F '?' for an unknown byte.
REQ-023 Latency SHALL be exactly 2 cycles: rx_done in cycle N with the FSM in IDLE and the hold register empty produces the command pulse, toggle, err or cmd_cnt change in cycle N+2.
REQ-024 At most one command pulse SHALL be high in any cycle, and each pulse SHALL be exactly one cycle wide.
REQ-025 A one-entry hold register SHALL capture rx_done bytes that arrive while the FSM is not in IDLE, or while the FSM is in IDLE and the hold register is being consumed in the same cycle.
REQ-026 An rx_done arriving while the hold register is full and not being consumed in that cycle SHALL drop the byte and pulse overrun in the next cycle.
REQ-027 cmd_cnt SHALL increment by 1 for each valid command, including 'X', and SHALL wrap from 255 to 0.

Reset
REQ-028 While rst=1, all pulse outputs, err, overrun and tx_start SHALL be 0 in the following cycle.
REQ-029 On rst=1, time_mode=0, func_mode=0, tx_data=0x00, cmd_cnt=0, the hold register SHALL be empty and the FSM SHALL be in IDLE.
REQ-030 rst asserted mid-operation (DECODE or ECHO) SHALL abandon the pending pulse and echo, with no tx_start after reset.
REQ-031 rx_done during rst=1 SHALL be ignored.

Verification
REQ-032 Reset, then rx 0x75 'u' at cycle N -> up=1 only in cycle N+2; tx_start with tx_data=0x55 once tx_busy=0; cmd_cnt=1.
REQ-033 Rx 'M', 'm', 'F' -> time_mode goes 1 then 0, func_mode=1; then rx 'X' -> reset pulse, both modes 0, cmd_cnt=4.
REQ-034 Rx 0x31 -> err pulse, no command pulse, tx_data=0x3F, cmd_cnt unchanged.
REQ-035 Hold tx_busy=1, rx 'G' then 'S' then 'C' -> run executes, 'S' is held, 'C' is dropped with an overrun pulse; release tx_busy -> echoes 0x47 then 0x53, and stop pulses.
REQ-036 ECHO_EN=0, 256 consecutive 'R' bytes 3 cycles apart -> 256 right pulses, tx_start never asserted, cmd_cnt wraps to 0.
REQ-037 rst asserted in the cycle after rx_done -> no command pulse, no tx_start; all outputs at reset values.

Source files
------------

// File: rtl/uart_cmd_decoder.sv
// UART command decoder: maps received ASCII bytes to watch/stopwatch controls.
// Two-cycle decode latency, one-entry hold buffer, optional byte echo.
module uart_cmd_decoder #(
    parameter int unsigned ECHO_EN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       tx_busy,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic       run,
    output logic       stop,
    output logic       clear,
    output logic       reset,
    output logic       time_mode,
    output logic       func_mode,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       err,
    output logic       overrun,
    output logic [7:0] cmd_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        ECHO
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_vld_q, hold_vld_d;
    logic [7:0] pulse_q, pulse_d;
    logic       err_q, err_d;
    logic       ovr_q, ovr_d;
    logic       tm_q, tm_d;
    logic       fm_q, fm_d;
    logic       txs_q, txs_d;
    logic [7:0] txd_q, txd_d;
    logic [7:0] cnt_q, cnt_d;

    logic [7:0] up_c;
    logic [7:0] cmd_oh;
    logic       cmd_vld;
    logic       tog_tm;
    logic       tog_fm;
    logic       take;
    logic       consume;

    assign up_c = byte_q & 8'hDF;

    // Table lookup of the latched byte; pulse bits are {up..reset}.
    always_comb begin
        cmd_oh  = 8'h00;
        cmd_vld = 1'b1;
        tog_tm  = 1'b0;
        tog_fm  = 1'b0;
        unique case (up_c)
            8'h55:   cmd_oh = 8'b1000_0000;
            8'h44:   cmd_oh = 8'b0100_0000;
            8'h4C:   cmd_oh = 8'b0010_0000;
            8'h52:   cmd_oh = 8'b0001_0000;
            8'h47:   cmd_oh = 8'b0000_1000;
            8'h53:   cmd_oh = 8'b0000_0100;
            8'h43:   cmd_oh = 8'b0000_0010;
            8'h58:   cmd_oh = 8'b0000_0001;
            8'h4D:   tog_tm = 1'b1;
            8'h46:   tog_fm = 1'b1;
            default: cmd_vld = 1'b0;
        endcase
    end

    // Next-state logic for the FSM, hold buffer and all registered outputs.
    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        pulse_d    = 8'h00;
        err_d      = 1'b0;
        ovr_d      = 1'b0;
        tm_d       = tm_q;
        fm_d       = fm_q;
        txs_d      = 1'b0;
        txd_d      = txd_q;
        cnt_d      = cnt_q;
        take       = 1'b0;
        consume    = 1'b0;
        case (state_q)
            IDLE: begin
                if (hold_vld_q) begin
                    byte_d  = hold_q;
                    consume = 1'b1;
                    state_d = DECODE;
                end else if (rx_done) begin
                    byte_d  = rx_data;
                    take    = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (cmd_vld) begin
                    pulse_d = cmd_oh;
                    cnt_d   = cnt_q + 8'd1;
                    if (cmd_oh[0]) begin
                        tm_d = 1'b0;
                        fm_d = 1'b0;
                    end else begin
                        if (tog_tm) tm_d = ~tm_q;
                        if (tog_fm) fm_d = ~fm_q;
                    end
                end else begin
                    err_d = 1'b1;
                end
                state_d = (ECHO_EN != 0) ? ECHO : IDLE;
            end
            ECHO: begin
                if (!tx_busy) begin
                    txs_d   = 1'b1;
                    txd_d   = cmd_vld ? up_c : 8'h3F;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (consume) hold_vld_d = 1'b0;
        if (rx_done && !take) begin
            if (!hold_vld_q || consume) begin
                hold_d     = rx_data;
                hold_vld_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // State register; reset discards any byte in flight and pending echo.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_q     <= 8'h00;
            hold_q     <= 8'h00;
            hold_vld_q <= 1'b0;
            pulse_q    <= 8'h00;
            err_q      <= 1'b0;
            ovr_q      <= 1'b0;
            tm_q       <= 1'b0;
            fm_q       <= 1'b0;
            txs_q      <= 1'b0;
            txd_q      <= 8'h00;
            cnt_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            pulse_q    <= pulse_d;
            err_q      <= err_d;
            ovr_q      <= ovr_d;
            tm_q       <= tm_d;
            fm_q       <= fm_d;
            txs_q      <= txs_d;
            txd_q      <= txd_d;
            cnt_q      <= cnt_d;
        end
    end

    assign up        = pulse_q[7];
    assign down      = pulse_q[6];
    assign left      = pulse_q[5];
    assign right     = pulse_q[4];
    assign run       = pulse_q[3];
    assign stop      = pulse_q[2];
    assign clear     = pulse_q[1];
    assign reset     = pulse_q[0];
    assign time_mode = tm_q;
    assign func_mode = fm_q;
    assign tx_start  = txs_q;
    assign tx_data   = txd_q;
    assign err       = err_q;
    assign overrun   = ovr_q;
    assign cmd_cnt   = cnt_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: table of command bytes plus hand sequences
// for busy/hold/overrun, mid-operation reset and the no-echo build.
module tb_uart_cmd_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_busy = 1'b0;
    logic       p_up, p_down, p_left, p_right, p_run, p_stop, p_clear, p_reset;
    logic       tm, fm, tx_start, err, overrun;
    logic [7:0] tx_data, cnt;

    logic       rx_done2 = 1'b0;
    logic [7:0] rx_data2 = 8'h00;
    logic       q_up, q_down, q_left, q_right, q_run, q_stop, q_clear, q_reset;
    logic       tm2, fm2, tx_start2, err2, overrun2;
    logic [7:0] tx_data2, cnt2;

    uart_cmd_decoder #(.ECHO_EN(1)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
        .tx_busy(tx_busy), .up(p_up), .down(p_down), .left(p_left),
        .right(p_right), .run(p_run), .stop(p_stop), .clear(p_clear),
        .reset(p_reset), .time_mode(tm), .func_mode(fm),
        .tx_start(tx_start), .tx_data(tx_data), .err(err),
        .overrun(overrun), .cmd_cnt(cnt)
    );

    uart_cmd_decoder #(.ECHO_EN(0)) dut2 (
        .clk(clk), .rst(rst), .rx_data(rx_data2), .rx_done(rx_done2),
        .tx_busy(1'b0), .up(q_up), .down(q_down), .left(q_left),
        .right(q_right), .run(q_run), .stop(q_stop), .clear(q_clear),
        .reset(q_reset), .time_mode(tm2), .func_mode(fm2),
        .tx_start(tx_start2), .tx_data(tx_data2), .err(err2),
        .overrun(overrun2), .cmd_cnt(cnt2)
    );

    localparam logic [8:0] V_NONE = 9'h000;
    localparam logic [8:0] V_UP   = 9'h100;
    localparam logic [8:0] V_DN   = 9'h080;
    localparam logic [8:0] V_LF   = 9'h040;
    localparam logic [8:0] V_RT   = 9'h020;
    localparam logic [8:0] V_RUN  = 9'h010;
    localparam logic [8:0] V_STP  = 9'h008;
    localparam logic [8:0] V_CLR  = 9'h004;
    localparam logic [8:0] V_RST  = 9'h002;
    localparam logic [8:0] V_ERR  = 9'h001;

    typedef struct {
        int         cyc;
        logic [8:0] vec;
        logic       tm;
        logic       fm;
        logic [7:0] cnt;
    } exp_t;

    typedef struct {
        logic [7:0] rx;
        logic [8:0] vec;
        logic [7:0] tx;
        logic       tm;
        logic       fm;
        logic [7:0] cnt;
    } vec_t;

    exp_t       cq[$];
    logic [7:0] txq[$];
    vec_t       tbl[16];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    logic [7:0] prev_cnt = 8'h00;

    int rt_cnt = 0;
    int tx2_cnt = 0;
    int other2 = 0;
    int first_rt = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic send2(input logic [7:0] b);
        rx_data2 = b;
        rx_done2 = 1'b1;
        tick();
        rx_done2 = 1'b0;
        rx_data2 = 8'h00;
    endtask

    task automatic push(input int c, input logic [8:0] v, input logic t,
                        input logic f, input logic [7:0] n);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        e.tm  = t;
        e.fm  = f;
        e.cnt = n;
        cq.push_back(e);
    endtask

    task automatic chk_reset_vals(input string name);
        chk(name, {p_up, p_down, p_left, p_right, p_run, p_stop, p_clear,
                   p_reset, err, overrun, tx_start, tm, fm},
            32'h0);
        chk({name, "_cnt_txd"}, {cnt, tx_data}, 32'h0);
    endtask

    // Scoreboard monitor for the echoing instance.
    always @(negedge clk) begin
        logic [8:0] v;
        exp_t       e;
        v = {p_up, p_down, p_left, p_right, p_run, p_stop, p_clear,
             p_reset, err};
        if (mon_en && !rst) begin
            if (v != 9'h0 || cnt != prev_cnt) begin
                if (cq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got vec=%h cnt=%0d expected none (cycle %0d)",
                             v, cnt, cyc);
                end else begin
                    e = cq.pop_front();
                    chk("cmd_vec", {23'h0, v}, {23'h0, e.vec});
                    if (e.cyc >= 0) chk("latency", cyc, e.cyc);
                    chk("modes_cnt", {tm, fm, cnt}, {e.tm, e.fm, e.cnt});
                    chk("onehot", {31'h0, $countones(v[8:1]) <= 1}, 32'h1);
                end
            end
            if (tx_start) begin
                if (txq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tx: got tx_start data=%h expected none (cycle %0d)",
                             tx_data, cyc);
                end else begin
                    chk("tx_data", tx_data, txq.pop_front());
                end
            end
        end
        prev_cnt = cnt;
    end

    // Counters for the non-echoing instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (q_right) begin
                rt_cnt++;
                if (first_rt < 0) first_rt = cyc;
            end
            if (tx_start2) tx2_cnt++;
            if (q_up | q_down | q_left | q_run | q_stop | q_clear |
                q_reset | err2 | overrun2) other2++;
        end
    end

    initial begin
        int c;
        int c2;
        tbl[0]  = '{8'h75, V_UP,   8'h55, 1'b0, 1'b0, 8'd1};
        tbl[1]  = '{8'h4D, V_NONE, 8'h4D, 1'b1, 1'b0, 8'd2};
        tbl[2]  = '{8'h6D, V_NONE, 8'h4D, 1'b0, 1'b0, 8'd3};
        tbl[3]  = '{8'h46, V_NONE, 8'h46, 1'b0, 1'b1, 8'd4};
        tbl[4]  = '{8'h6D, V_NONE, 8'h4D, 1'b1, 1'b1, 8'd5};
        tbl[5]  = '{8'h58, V_RST,  8'h58, 1'b0, 1'b0, 8'd6};
        tbl[6]  = '{8'h31, V_ERR,  8'h3F, 1'b0, 1'b0, 8'd6};
        tbl[7]  = '{8'h64, V_DN,   8'h44, 1'b0, 1'b0, 8'd7};
        tbl[8]  = '{8'h6C, V_LF,   8'h4C, 1'b0, 1'b0, 8'd8};
        tbl[9]  = '{8'h72, V_RT,   8'h52, 1'b0, 1'b0, 8'd9};
        tbl[10] = '{8'h67, V_RUN,  8'h47, 1'b0, 1'b0, 8'd10};
        tbl[11] = '{8'h73, V_STP,  8'h53, 1'b0, 1'b0, 8'd11};
        tbl[12] = '{8'h63, V_CLR,  8'h43, 1'b0, 1'b0, 8'd12};
        tbl[13] = '{8'h15, V_ERR,  8'h3F, 1'b0, 1'b0, 8'd12};
        tbl[14] = '{8'h7F, V_ERR,  8'h3F, 1'b0, 1'b0, 8'd12};
        tbl[15] = '{8'h66, V_NONE, 8'h46, 1'b0, 1'b1, 8'd13};

        // Reset with an rx_done strobe that must be ignored.
        rst = 1'b1;
        tick();
        rx_data = 8'h55;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        tick();
        @(negedge clk);
        chk_reset_vals("reset_state");
        tick();
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (6) tick();

        // Table of single commands, one every 4 cycles.
        for (int i = 0; i < 16; i++) begin
            c = cyc;
            if (tbl[i].vec != V_NONE || tbl[i].cnt != 8'd0)
                push(c + 2, tbl[i].vec, tbl[i].tm, tbl[i].fm, tbl[i].cnt);
            txq.push_back(tbl[i].tx);
            send(tbl[i].rx);
            repeat (3) tick();
        end
        repeat (4) tick();
        chk("table_cq_drained", cq.size(), 0);
        chk("table_txq_drained", txq.size(), 0);

        // Busy transmitter: G runs, S waits in hold, C is dropped.
        tx_busy = 1'b1;
        c = cyc;
        push(c + 2, V_RUN, 1'b0, 1'b1, 8'd14);
        txq.push_back(8'h47);
        send(8'h47);
        tick();
        push(-1, V_STP, 1'b0, 1'b1, 8'd15);
        txq.push_back(8'h53);
        send(8'h53);
        tick();
        send(8'h43);
        @(negedge clk);
        chk("overrun_pulse", {31'h0, overrun}, 32'h1);
        tick();
        @(negedge clk);
        chk("overrun_width", {31'h0, overrun}, 32'h0);
        repeat (4) tick();
        chk("no_tx_while_busy", txq.size(), 2);
        chk("stop_held", cq.size(), 1);
        tx_busy = 1'b0;
        repeat (12) tick();
        chk("busy_cq_drained", cq.size(), 0);
        chk("busy_txq_drained", txq.size(), 0);

        // Reset in the cycle after rx_done: nothing may come out.
        send(8'h55);
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk_reset_vals("rst_in_decode");
        tick();
        rst = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        chk_reset_vals("after_rst_decode");
        tick();

        // Reset while waiting in ECHO: pulse seen, echo abandoned.
        tx_busy = 1'b1;
        c = cyc;
        push(c + 2, V_LF, 1'b0, 1'b0, 8'd1);
        send(8'h4C);
        repeat (2) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tx_busy = 1'b0;
        repeat (8) tick();
        chk("echo_rst_cq", cq.size(), 0);
        @(negedge clk);
        chk_reset_vals("after_rst_echo");
        tick();

        // No-echo instance: 256 'R' bytes, 3 cycles apart.
        c2 = cyc;
        for (int i = 0; i < 255; i++) begin
            send2(8'h52);
            repeat (2) tick();
        end
        repeat (2) tick();
        chk("noecho_cnt_255", cnt2, 8'd255);
        send2(8'h72);
        repeat (4) tick();
        chk("noecho_first_latency", first_rt, c2 + 2);
        chk("noecho_right_count", rt_cnt, 256);
        chk("noecho_tx_start", tx2_cnt, 0);
        chk("noecho_other_outputs", other2, 0);
        chk("noecho_cnt_wrap", cnt2, 8'd0);
        chk("noecho_txd", tx_data2, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
